// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared widths, access-size encodings, FSM states and
// the byte-lane pattern helper used by the MEM-stage load/store unit.
`ifndef DWIDTH
`define DWIDTH 32
`endif
`ifndef AWIDTH_MEM
`define AWIDTH_MEM 8
`endif

package mem_access_unit_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_t;

  // Lane pattern before shifting by the byte offset; 2'b11 is also a word.
  function automatic logic [3:0] size_pattern(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 4'b0001;
      SIZE_HALF: return 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: EX/MEM entry, data-memory port, MEM/WB result and trap
// signals of the load/store unit, plus the FSM state for observation.
//
// Handshake: an entry is offered when i_valid is high. While o_stall is high
// the upstream stage must hold every i_* input stable; the entry is consumed
// on the first posedge with o_stall low. There is no other back-pressure.
interface mem_access_unit_if
  import mem_access_unit_pkg::*;
#(
  parameter int DWIDTH = `DWIDTH,
  parameter int AW     = `AWIDTH_MEM
) ();

  logic              i_valid;
  logic              i_flush;
  logic              i_load;
  logic              i_store;
  logic [1:0]        i_size;
  logic              i_unsigned;
  logic [31:0]       i_addr;
  logic [DWIDTH-1:0] i_store_data;
  logic [4:0]        i_rd;
  logic              o_stall;
  logic              o_mem_ce;
  logic              o_mem_wr_en;
  logic [3:0]        o_mem_mask;
  logic [AW-1:0]     o_mem_addr;
  logic [DWIDTH-1:0] o_mem_store_data;
  logic [DWIDTH-1:0] i_mem_load_data;
  logic              o_wb_valid;
  logic              o_wb_load;
  logic [4:0]        o_wb_rd;
  logic [DWIDTH-1:0] o_wb_data;
  logic              o_exc_misalign;
  logic [31:0]       o_exc_addr;
  state_t            o_dbg_state;

  modport slave (
    input  i_valid, i_flush, i_load, i_store, i_size, i_unsigned, i_addr,
           i_store_data, i_rd, i_mem_load_data,
    output o_stall, o_mem_ce, o_mem_wr_en, o_mem_mask, o_mem_addr,
           o_mem_store_data, o_wb_valid, o_wb_load, o_wb_rd, o_wb_data,
           o_exc_misalign, o_exc_addr, o_dbg_state
  );

  modport master (
    output i_valid, i_flush, i_load, i_store, i_size, i_unsigned, i_addr,
           i_store_data, i_rd, i_mem_load_data,
    input  o_stall, o_mem_ce, o_mem_wr_en, o_mem_mask, o_mem_addr,
           o_mem_store_data, o_wb_valid, o_wb_load, o_wb_rd, o_wb_data,
           o_exc_misalign, o_exc_addr, o_dbg_state
  );

endinterface

// File: rtl/mem_access_unit_load_extend.sv
// mem_access_unit_load_extend: selects the addressed byte/half/word out of a
// two-word little-endian read window and sign- or zero-extends it.
module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
#(
  parameter int DWIDTH = `DWIDTH
) (
  input  logic [2*DWIDTH-1:0] win_i,
  input  logic [1:0]          off_i,
  input  logic [1:0]          size_i,
  input  logic                unsigned_i,
  output logic [DWIDTH-1:0]   data_o
);

  logic [DWIDTH-1:0] shifted;

  // Shift the window down by the byte offset, then truncate and extend.
  always_comb begin
    shifted = DWIDTH'(win_i >> {off_i, 3'b000});
    case (size_i)
      SIZE_BYTE: data_o = {{(DWIDTH-8){~unsigned_i & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: data_o = {{(DWIDTH-16){~unsigned_i & shifted[15]}}, shifted[15:0]};
      default:   data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit. Turns byte addresses into a word
// index, lane mask and lane-aligned store data, extends load data and
// registers the MEM/WB result.
// Build option MEM_MISALIGN_SPLIT_EN: misaligned half/word accesses complete
// over two memory cycles (IDLE -> SPLIT); when undefined they are dropped and
// reported one cycle later through o_exc_misalign / o_exc_addr.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DWIDTH = `DWIDTH,
  parameter int AW     = `AWIDTH_MEM
) (
  input logic              m_clk,
  input logic              m_rst,
  mem_access_unit_if.slave bus
);

  logic [1:0]          off;
  logic [AW-1:0]       w;
  logic [7:0]          mask8;
  logic [2*DWIDTH-1:0] data64;
  logic                misalign;
  logic                hi_sel;
  logic                active;
  logic                is_mem;
  logic                ce;
  logic                stall;
  logic [2*DWIDTH-1:0] win;
  logic [DWIDTH-1:0]   ld_data;

  state_t            state_q, state_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_load_q, wb_load_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [DWIDTH-1:0] wb_data_q, wb_data_d;
`ifdef MEM_MISALIGN_SPLIT_EN
  logic [DWIDTH-1:0] lo_q, lo_d;
`else
  logic              exc_q, exc_d;
  logic [31:0]       exc_addr_q, exc_addr_d;
`endif

  // Lane geometry: the access spans up to two words; hi_sel picks the upper one.
  always_comb begin
    off      = bus.i_addr[1:0];
    w        = bus.i_addr[AW+1:2];
    mask8    = {4'b0000, size_pattern(bus.i_size)} << off;
    data64   = {{DWIDTH{1'b0}}, bus.i_store_data} << {off, 3'b000};
    misalign = |mask8[7:4];
    hi_sel   = (state_q == ST_SPLIT);
    active   = bus.i_valid & ~bus.i_flush;
    is_mem   = bus.i_load | bus.i_store;
  end

  // Read window: upper word zero for single-word loads, low half from lo_q in SPLIT.
  always_comb begin
`ifdef MEM_MISALIGN_SPLIT_EN
    win = hi_sel ? {bus.i_mem_load_data, lo_q}
                 : {{DWIDTH{1'b0}}, bus.i_mem_load_data};
`else
    win = {{DWIDTH{1'b0}}, bus.i_mem_load_data};
`endif
  end

  mem_access_unit_load_extend #(.DWIDTH(DWIDTH)) u_load_extend (
    .win_i      (win),
    .off_i      (off),
    .size_i     (bus.i_size),
    .unsigned_i (bus.i_unsigned),
    .data_o     (ld_data)
  );

  // Next-state, memory enable, stall and MEM/WB result selection.
  always_comb begin
    state_d    = ST_IDLE;
    ce         = 1'b0;
    stall      = 1'b0;
    wb_valid_d = 1'b0;
    wb_load_d  = 1'b0;
    wb_rd_d    = bus.i_rd;
    wb_data_d  = bus.i_addr;
`ifdef MEM_MISALIGN_SPLIT_EN
    lo_d       = lo_q;
`else
    exc_d      = 1'b0;
    exc_addr_d = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (active) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
          end else if (!misalign) begin
            ce         = 1'b1;
            wb_valid_d = 1'b1;
            wb_load_d  = ~bus.i_store;
            if (!bus.i_store) wb_data_d = ld_data;
          end else begin
`ifdef MEM_MISALIGN_SPLIT_EN
            ce      = 1'b1;
            stall   = 1'b1;
            lo_d    = bus.i_mem_load_data;
            state_d = ST_SPLIT;
`else
            exc_d      = 1'b1;
            exc_addr_d = bus.i_addr;
`endif
          end
        end
      end
      ST_SPLIT: begin
        // A flush or dropped valid here abandons only the second half.
        if (active) begin
          ce         = 1'b1;
          wb_valid_d = 1'b1;
          wb_load_d  = ~bus.i_store;
          if (!bus.i_store) wb_data_d = ld_data;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory port is quiet (all zero) whenever no access is issued.
  always_comb begin
    bus.o_stall          = stall;
    bus.o_mem_ce         = ce;
    bus.o_mem_wr_en      = ce & bus.i_store;
    bus.o_mem_addr       = ce ? (w + AW'(hi_sel)) : '0;
    bus.o_mem_mask       = ce ? (hi_sel ? mask8[7:4] : mask8[3:0]) : 4'b0000;
    bus.o_mem_store_data = ce ? (hi_sel ? data64[2*DWIDTH-1:DWIDTH]
                                        : data64[DWIDTH-1:0]) : '0;
    bus.o_wb_valid       = wb_valid_q;
    bus.o_wb_load        = wb_load_q;
    bus.o_wb_rd          = wb_rd_q;
    bus.o_wb_data        = wb_data_q;
    bus.o_dbg_state      = state_q;
`ifdef MEM_MISALIGN_SPLIT_EN
    bus.o_exc_misalign   = 1'b0;
    bus.o_exc_addr       = '0;
`else
    bus.o_exc_misalign   = exc_q;
    bus.o_exc_addr       = exc_addr_q;
`endif
  end

  // FSM state and MEM/WB pipeline register.
  always_ff @(posedge m_clk or negedge m_rst) begin
    if (!m_rst) begin
      state_q    <= ST_IDLE;
      wb_valid_q <= 1'b0;
      wb_load_q  <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_load_q  <= wb_load_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

`ifdef MEM_MISALIGN_SPLIT_EN
  // Low read word of a split access, kept for the SPLIT cycle.
  always_ff @(posedge m_clk or negedge m_rst) begin
    if (!m_rst) lo_q <= '0;
    else        lo_q <= lo_d;
  end
`else
  // One-cycle misalignment trap pulse with the faulting address.
  always_ff @(posedge m_clk or negedge m_rst) begin
    if (!m_rst) begin
      exc_q      <= 1'b0;
      exc_addr_q <= '0;
    end else begin
      exc_q      <= exc_d;
      exc_addr_q <= exc_addr_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed tests of the MEM-stage load/store unit against
// a word-addressed memory model that writes on negedge.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic m_clk = 1'b0;
  logic m_rst = 1'b0;
  logic mem_init = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic [31:0] mem [0:255];

  // Clock
  always #5 m_clk = ~m_clk;

  mem_access_unit_if #(.DWIDTH(32), .AW(8)) bus ();

  mem_access_unit #(.DWIDTH(32), .AW(8)) dut (
    .m_clk (m_clk),
    .m_rst (m_rst),
    .bus   (bus.slave)
  );

  // Combinational read, masked write on negedge, word i initialised to i.
  assign bus.i_mem_load_data = mem[bus.o_mem_addr];

  always @(negedge m_clk) begin
    logic [31:0] nw;
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
    end else if (bus.o_mem_ce && bus.o_mem_wr_en) begin
      nw = mem[bus.o_mem_addr];
      for (int b = 0; b < 4; b++)
        if (bus.o_mem_mask[b]) nw[8*b +: 8] = bus.o_mem_store_data[8*b +: 8];
      mem[bus.o_mem_addr] <= nw;
    end
  end

  // Driver tasks
  task automatic clear_in();
    bus.i_valid      = 1'b0;
    bus.i_flush      = 1'b0;
    bus.i_load       = 1'b0;
    bus.i_store      = 1'b0;
    bus.i_size       = 2'b00;
    bus.i_unsigned   = 1'b0;
    bus.i_addr       = 32'h0;
    bus.i_store_data = 32'h0;
    bus.i_rd         = 5'd0;
  endtask

  task automatic set_access(input logic ld, input logic st, input logic [1:0] sz,
                            input logic uns, input logic [31:0] addr,
                            input logic [31:0] sd, input logic [4:0] rd);
    bus.i_valid      = 1'b1;
    bus.i_flush      = 1'b0;
    bus.i_load       = ld;
    bus.i_store      = st;
    bus.i_size       = sz;
    bus.i_unsigned   = uns;
    bus.i_addr       = addr;
    bus.i_store_data = sd;
    bus.i_rd         = rd;
  endtask

  task automatic tick();
    @(posedge m_clk);
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    m_rst = 1'b0;
    mem_init = 1'b1;
    @(posedge m_clk);
    @(posedge m_clk);
    mem_init = 1'b0;
    @(negedge m_clk);
    m_rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_in();
    m_rst = 1'b0;
    mem_init = 1'b1;
    tick();
    total_cnt++; if (bus.o_wb_valid !== 1'b0) $display("FAIL rst_wb_valid: got %0h want 0", bus.o_wb_valid); else pass_cnt++;
    total_cnt++; if (bus.o_wb_data !== 32'h0) $display("FAIL rst_wb_data: got %08h want 00000000", bus.o_wb_data); else pass_cnt++;
    total_cnt++; if (bus.o_exc_misalign !== 1'b0) $display("FAIL rst_exc: got %0h want 0", bus.o_exc_misalign); else pass_cnt++;
    total_cnt++; if (bus.o_exc_addr !== 32'h0) $display("FAIL rst_exc_addr: got %08h want 0", bus.o_exc_addr); else pass_cnt++;
    total_cnt++; if (bus.o_stall !== 1'b0) $display("FAIL rst_stall: got %0h want 0", bus.o_stall); else pass_cnt++;
    total_cnt++; if (bus.o_mem_ce !== 1'b0) $display("FAIL rst_ce: got %0h want 0", bus.o_mem_ce); else pass_cnt++;
    total_cnt++; if (bus.o_mem_mask !== 4'b0) $display("FAIL rst_mask: got %b want 0000", bus.o_mem_mask); else pass_cnt++;
    total_cnt++; if (bus.o_dbg_state !== ST_IDLE) $display("FAIL rst_state: got %0d want IDLE", bus.o_dbg_state); else pass_cnt++;
    @(posedge m_clk);
    mem_init = 1'b0;
    @(negedge m_clk);
    m_rst = 1'b1;
    tick();
  endtask

  task automatic test_load_byte();
    set_access(1'b1, 1'b0, SIZE_BYTE, 1'b1, 32'h14, 32'h0, 5'd7);
    #2;
    total_cnt++; if (bus.o_mem_ce !== 1'b1) $display("FAIL lbu_ce: got %0h want 1", bus.o_mem_ce); else pass_cnt++;
    total_cnt++; if (bus.o_mem_wr_en !== 1'b0) $display("FAIL lbu_wr_en: got %0h want 0", bus.o_mem_wr_en); else pass_cnt++;
    total_cnt++; if (bus.o_mem_addr !== 8'd5) $display("FAIL lbu_addr: got %0d want 5", bus.o_mem_addr); else pass_cnt++;
    total_cnt++; if (bus.o_mem_mask !== 4'b0001) $display("FAIL lbu_mask: got %b want 0001", bus.o_mem_mask); else pass_cnt++;
    tick();
    clear_in();
    total_cnt++; if (bus.o_wb_valid !== 1'b1) $display("FAIL lbu_wb_valid: got %0h want 1", bus.o_wb_valid); else pass_cnt++;
    total_cnt++; if (bus.o_wb_load !== 1'b1) $display("FAIL lbu_wb_load: got %0h want 1", bus.o_wb_load); else pass_cnt++;
    total_cnt++; if (bus.o_wb_data !== 32'h00000005) $display("FAIL lbu_wb_data: got %08h want 00000005", bus.o_wb_data); else pass_cnt++;
    total_cnt++; if (bus.o_wb_rd !== 5'd7) $display("FAIL lbu_wb_rd: got %0d want 7", bus.o_wb_rd); else pass_cnt++;
    tick();
    total_cnt++; if (bus.o_wb_valid !== 1'b0) $display("FAIL idle_wb_valid: got %0h want 0", bus.o_wb_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    set_access(1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h8, 32'hDEADBEEF, 5'd0);
    #2;
    total_cnt++; if (bus.o_mem_mask !== 4'b1111) $display("FAIL sw_mask: got %b want 1111", bus.o_mem_mask); else pass_cnt++;
    total_cnt++; if (bus.o_mem_addr !== 8'd2) $display("FAIL sw_addr: got %0d want 2", bus.o_mem_addr); else pass_cnt++;
    total_cnt++; if (bus.o_mem_wr_en !== 1'b1) $display("FAIL sw_wr_en: got %0h want 1", bus.o_mem_wr_en); else pass_cnt++;
    total_cnt++; if (bus.o_mem_store_data !== 32'hDEADBEEF) $display("FAIL sw_data: got %08h want DEADBEEF", bus.o_mem_store_data); else pass_cnt++;
    tick();
    total_cnt++; if (bus.o_wb_load !== 1'b0) $display("FAIL sw_wb_load: got %0h want 0", bus.o_wb_load); else pass_cnt++;
    set_access(1'b1, 1'b0, SIZE_BYTE, 1'b0, 32'hB, 32'h0, 5'd3);
    tick();
    total_cnt++; if (bus.o_wb_data !== 32'hFFFFFFDE) $display("FAIL lb_b_data: got %08h want FFFFFFDE", bus.o_wb_data); else pass_cnt++;
    set_access(1'b1, 1'b0, SIZE_HALF, 1'b1, 32'hA, 32'h0, 5'd4);
    tick();
    clear_in();
    total_cnt++; if (bus.o_wb_data !== 32'h0000DEAD) $display("FAIL lhu_a_data: got %08h want 0000DEAD", bus.o_wb_data); else pass_cnt++;
    total_cnt++; if (bus.o_wb_rd !== 5'd4) $display("FAIL lhu_a_rd: got %0d want 4", bus.o_wb_rd); else pass_cnt++;
  endtask

  task automatic test_store_byte();
    set_access(1'b0, 1'b1, SIZE_BYTE, 1'b0, 32'h9, 32'h000000AA, 5'd0);
    #2;
    total_cnt++; if (bus.o_mem_mask !== 4'b0010) $display("FAIL sb_mask: got %b want 0010", bus.o_mem_mask); else pass_cnt++;
    total_cnt++; if (bus.o_mem_store_data !== 32'h0000AA00) $display("FAIL sb_data: got %08h want 0000AA00", bus.o_mem_store_data); else pass_cnt++;
    tick();
    set_access(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h8, 32'h0, 5'd1);
    tick();
    total_cnt++; if (bus.o_wb_data !== 32'hDEADAAEF) $display("FAIL lw_8_data: got %08h want DEADAAEF", bus.o_wb_data); else pass_cnt++;
    set_access(1'b1, 1'b0, SIZE_HALF, 1'b1, 32'h9, 32'h0, 5'd2);
    tick();
    total_cnt++; if (bus.o_wb_data !== 32'h0000ADAA) $display("FAIL lhu_9_data: got %08h want 0000ADAA", bus.o_wb_data); else pass_cnt++;
    set_access(1'b1, 1'b0, SIZE_HALF, 1'b0, 32'h8, 32'h0, 5'd2);
    tick();
    clear_in();
    total_cnt++; if (bus.o_wb_data !== 32'hFFFFAAEF) $display("FAIL lh_8_data: got %08h want FFFFAAEF", bus.o_wb_data); else pass_cnt++;
  endtask

  task automatic test_non_mem();
    set_access(1'b0, 1'b0, SIZE_WORD, 1'b0, 32'h12345678, 32'h0, 5'd9);
    #2;
    total_cnt++; if (bus.o_mem_ce !== 1'b0) $display("FAIL alu_ce: got %0h want 0", bus.o_mem_ce); else pass_cnt++;
    tick();
    clear_in();
    total_cnt++; if (bus.o_wb_valid !== 1'b1) $display("FAIL alu_wb_valid: got %0h want 1", bus.o_wb_valid); else pass_cnt++;
    total_cnt++; if (bus.o_wb_load !== 1'b0) $display("FAIL alu_wb_load: got %0h want 0", bus.o_wb_load); else pass_cnt++;
    total_cnt++; if (bus.o_wb_data !== 32'h12345678) $display("FAIL alu_wb_data: got %08h want 12345678", bus.o_wb_data); else pass_cnt++;
  endtask

  task automatic test_load_and_store();
    set_access(1'b1, 1'b1, SIZE_WORD, 1'b0, 32'hC, 32'h0BADF00D, 5'd6);
    #2;
    total_cnt++; if (bus.o_mem_wr_en !== 1'b1) $display("FAIL ldst_wr_en: got %0h want 1", bus.o_mem_wr_en); else pass_cnt++;
    tick();
    total_cnt++; if (bus.o_wb_load !== 1'b0) $display("FAIL ldst_wb_load: got %0h want 0", bus.o_wb_load); else pass_cnt++;
    set_access(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'hC, 32'h0, 5'd6);
    tick();
    clear_in();
    total_cnt++; if (bus.o_wb_data !== 32'h0BADF00D) $display("FAIL ldst_readback: got %08h want 0BADF00D", bus.o_wb_data); else pass_cnt++;
  endtask

  task automatic test_flush();
    set_access(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h8, 32'h0, 5'd8);
    bus.i_flush = 1'b1;
    #2;
    total_cnt++; if (bus.o_mem_ce !== 1'b0) $display("FAIL flush_ce: got %0h want 0", bus.o_mem_ce); else pass_cnt++;
    tick();
    clear_in();
    total_cnt++; if (bus.o_wb_valid !== 1'b0) $display("FAIL flush_wb_valid: got %0h want 0", bus.o_wb_valid); else pass_cnt++;
  endtask

  task automatic test_reset_inflight();
    set_access(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h8, 32'h0, 5'd8);
    #2;
    m_rst = 1'b0;
    clear_in();
    tick();
    total_cnt++; if (bus.o_wb_valid !== 1'b0) $display("FAIL rstfly_wb_valid: got %0h want 0", bus.o_wb_valid); else pass_cnt++;
    total_cnt++; if (bus.o_wb_data !== 32'h0) $display("FAIL rstfly_wb_data: got %08h want 0", bus.o_wb_data); else pass_cnt++;
    @(negedge m_clk);
    m_rst = 1'b1;
    tick();
  endtask

`ifdef MEM_MISALIGN_SPLIT_EN
  task automatic test_split_load();
    do_reset();
    set_access(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h6, 32'h0, 5'd5);
    #2;
    total_cnt++; if (bus.o_stall !== 1'b1) $display("FAIL split_stall1: got %0h want 1", bus.o_stall); else pass_cnt++;
    total_cnt++; if (bus.o_mem_addr !== 8'd1) $display("FAIL split_addr1: got %0d want 1", bus.o_mem_addr); else pass_cnt++;
    total_cnt++; if (bus.o_mem_mask !== 4'b1100) $display("FAIL split_mask1: got %b want 1100", bus.o_mem_mask); else pass_cnt++;
    tick();
    total_cnt++; if (bus.o_stall !== 1'b0) $display("FAIL split_stall2: got %0h want 0", bus.o_stall); else pass_cnt++;
    total_cnt++; if (bus.o_mem_addr !== 8'd2) $display("FAIL split_addr2: got %0d want 2", bus.o_mem_addr); else pass_cnt++;
    total_cnt++; if (bus.o_mem_mask !== 4'b0011) $display("FAIL split_mask2: got %b want 0011", bus.o_mem_mask); else pass_cnt++;
    total_cnt++; if (bus.o_dbg_state !== ST_SPLIT) $display("FAIL split_state: got %0d want SPLIT", bus.o_dbg_state); else pass_cnt++;
    total_cnt++; if (bus.o_wb_valid !== 1'b0) $display("FAIL split_wb_early: got %0h want 0", bus.o_wb_valid); else pass_cnt++;
    tick();
    clear_in();
    total_cnt++; if (bus.o_wb_valid !== 1'b1) $display("FAIL split_wb_valid: got %0h want 1", bus.o_wb_valid); else pass_cnt++;
    total_cnt++; if (bus.o_wb_data !== 32'h00020000) $display("FAIL split_wb_data: got %08h want 00020000", bus.o_wb_data); else pass_cnt++;
    total_cnt++; if (bus.o_exc_misalign !== 1'b0) $display("FAIL split_exc: got %0h want 0", bus.o_exc_misalign); else pass_cnt++;
  endtask

  task automatic test_split_flush();
    do_reset();
    set_access(1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h6, 32'h11223344, 5'd0);
    #2;
    total_cnt++; if (bus.o_mem_store_data !== 32'h33440000) $display("FAIL sflush_data1: got %08h want 33440000", bus.o_mem_store_data); else pass_cnt++;
    tick();
    bus.i_flush = 1'b1;
    #2;
    total_cnt++; if (bus.o_mem_ce !== 1'b0) $display("FAIL sflush_ce: got %0h want 0", bus.o_mem_ce); else pass_cnt++;
    tick();
    clear_in();
    total_cnt++; if (bus.o_wb_valid !== 1'b0) $display("FAIL sflush_wb_valid: got %0h want 0", bus.o_wb_valid); else pass_cnt++;
    total_cnt++; if (bus.o_dbg_state !== ST_IDLE) $display("FAIL sflush_state: got %0d want IDLE", bus.o_dbg_state); else pass_cnt++;
    total_cnt++; if (mem[1] !== 32'h33440001) $display("FAIL sflush_word1: got %08h want 33440001", mem[1]); else pass_cnt++;
    total_cnt++; if (mem[2] !== 32'h00000002) $display("FAIL sflush_word2: got %08h want 00000002", mem[2]); else pass_cnt++;
  endtask

  task automatic test_split_reset();
    do_reset();
    set_access(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h6, 32'h0, 5'd5);
    tick();
    #2;
    m_rst = 1'b0;
    clear_in();
    #1;
    total_cnt++; if (bus.o_stall !== 1'b0) $display("FAIL srst_stall: got %0h want 0", bus.o_stall); else pass_cnt++;
    total_cnt++; if (bus.o_mem_ce !== 1'b0) $display("FAIL srst_ce: got %0h want 0", bus.o_mem_ce); else pass_cnt++;
    total_cnt++; if (bus.o_dbg_state !== ST_IDLE) $display("FAIL srst_state: got %0d want IDLE", bus.o_dbg_state); else pass_cnt++;
    tick();
    @(negedge m_clk);
    m_rst = 1'b1;
    tick();
    total_cnt++; if (bus.o_wb_valid !== 1'b0) $display("FAIL srst_wb_valid: got %0h want 0", bus.o_wb_valid); else pass_cnt++;
    total_cnt++; if (bus.o_stall !== 1'b0) $display("FAIL srst_stall_after: got %0h want 0", bus.o_stall); else pass_cnt++;
  endtask
`else
  task automatic test_misalign_trap();
    set_access(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h6, 32'h0, 5'd5);
    #2;
    total_cnt++; if (bus.o_mem_ce !== 1'b0) $display("FAIL trap_ce: got %0h want 0", bus.o_mem_ce); else pass_cnt++;
    total_cnt++; if (bus.o_stall !== 1'b0) $display("FAIL trap_stall: got %0h want 0", bus.o_stall); else pass_cnt++;
    tick();
    clear_in();
    total_cnt++; if (bus.o_wb_valid !== 1'b0) $display("FAIL trap_wb_valid: got %0h want 0", bus.o_wb_valid); else pass_cnt++;
    total_cnt++; if (bus.o_exc_misalign !== 1'b1) $display("FAIL trap_exc: got %0h want 1", bus.o_exc_misalign); else pass_cnt++;
    total_cnt++; if (bus.o_exc_addr !== 32'h6) $display("FAIL trap_exc_addr: got %08h want 00000006", bus.o_exc_addr); else pass_cnt++;
    tick();
    total_cnt++; if (bus.o_exc_misalign !== 1'b0) $display("FAIL trap_pulse: got %0h want 0", bus.o_exc_misalign); else pass_cnt++;
    set_access(1'b1, 1'b0, SIZE_HALF, 1'b0, 32'h7, 32'h0, 5'd5);
    tick();
    clear_in();
    total_cnt++; if (bus.o_exc_addr !== 32'h7) $display("FAIL trap_half_addr: got %08h want 00000007", bus.o_exc_addr); else pass_cnt++;
    total_cnt++; if (bus.o_dbg_state !== ST_IDLE) $display("FAIL trap_state: got %0d want IDLE", bus.o_dbg_state); else pass_cnt++;
  endtask
`endif

  initial begin
    clear_in();
    test_reset();
    test_load_byte();
    test_back_to_back();
    test_store_byte();
    test_non_mem();
    test_load_and_store();
    test_flush();
    test_reset_inflight();
`ifdef MEM_MISALIGN_SPLIT_EN
    test_split_load();
    test_split_flush();
    test_split_reset();
`else
    test_misalign_trap();
`endif
    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store unit of the MIPS pipeline. It sits between the EX/MEM pipeline register and the word-addressed data memory. It converts byte addresses and access sizes into a word index, byte-lane mask and lane-aligned store data. It sign- or zero-extends returned load data and registers the result into the MEM/WB boundary. Misaligned halfword/word accesses are either split into two memory cycles or trapped, selected at compile time.

## Interface
Parameters:
- DWIDTH, `DWIDTH (32): data width.
- AW, `AWIDTH_MEM: memory word-index width.

Ports:
- m_clk  in  1  clock; all state updates on posedge.
- m_rst  in  1  reset, asynchronous, active-low.
- i_valid  in  1  EX/MEM entry valid.
- i_flush  in  1  synchronous kill of the current entry.
- i_load, i_store  in  1  access type.
- i_size  in  2  00 byte, 01 half, 10/11 word.
- i_unsigned  in  1  zero-extend loads.
- i_addr  in  32  ALU result / byte address.
- i_store_data  in  DWIDTH  rt value.
- i_rd  in  5  destination register.
- o_stall  out  1  upstream must hold all inputs.
- o_mem_ce, o_mem_wr_en  out  1  memory enable / write.
- o_mem_mask  out  4  byte-lane write mask.
- o_mem_addr  out  AW  word index.
- o_mem_store_data  out  DWIDTH  lane-aligned store data.
- i_mem_load_data  in  DWIDTH  combinational memory read data.
- o_wb_valid, o_wb_load  out  1  MEM/WB valid; result is load data.
- o_wb_rd  out  5, o_wb_data  out  DWIDTH  MEM/WB result.
- o_exc_misalign  out  1, o_exc_addr  out  32  misalignment trap pulse and address.

## Operation
- Word index: w = i_addr[AW+1:2]. Byte offset: off = i_addr[1:0]. Lane 0 = bits 7:0 (little-endian).
- Pattern p: 0001 for byte, 0011 for half, 1111 for word. Mask8 = p << off. Data64 = i_store_data << 8*off.
- Aligned access (mask8[7:4]==0):
  - Memory driven combinationally in the same cycle.
  - o_mem_ce=1, o_mem_wr_en=i_store, mask=mask8[3:0], store_data=data64[31:0].
- Load result:
  - (i_mem_load_data >> 8*off) truncated to size.
  - Sign-extended unless i_unsigned.
- Non-memory entry (valid, neither load nor store): ce=0; o_wb_data=i_addr, o_wb_load=0.
- i_load & i_store both set: treated as a store.
- FSM states:
  - IDLE: misaligned valid access -> SPLIT; first word w accessed with mask8[3:0] and data64[31:0]; low read word captured into lo_q.
  - SPLIT: o_stall=1 while entered from IDLE. Accesses word w+1 (wraps modulo 2^AW) with mask8[7:4] and data64[63:32]. Load result = ({i_mem_load_data, lo_q} >> 8*off), then extended. Returns to IDLE.
- i_flush: forces ce=0 this cycle, FSM->IDLE, o_wb_valid=0 next cycle. A flush in SPLIT suppresses the second half only; the first half remains committed.

## Timing
- Reset: all outputs 0, FSM IDLE, lo_q 0.
  - Reset mid-SPLIT abandons the access; no writeback, no stall after release.
- Aligned access: result on o_wb_* one posedge after i_valid sampled. Throughput 1/cycle.
- Split access: o_stall high for exactly the first cycle. Result one posedge after the SPLIT cycle (2-cycle latency).
- o_mem_* are combinational from inputs/state. The memory writes on negedge, so a store in cycle n is visible to a load in cycle n+1.
- o_exc_misalign: registered 1-cycle pulse.

## Configuration
- MEM_MISALIGN_SPLIT_EN defined: SPLIT state and lo_q present; misaligned accesses complete in two cycles; o_exc_misalign tied 0.
- MEM_MISALIGN_SPLIT_EN undefined:
  - Misaligned access drives ce=0, o_wb_valid=0 and o_stall=0.
  - Next cycle it pulses o_exc_misalign=1 with o_exc_addr=i_addr.
  - No SPLIT state.

## Structure
- Shared header gets the size encodings (SIZE_BYTE/HALF/WORD) and the FSM state constants, alongside `DWIDTH/`AWIDTH_MEM.
- One sub-module, load_extend: combinational shift/truncate/extend of a 64-bit window by offset, size and unsigned. It is reused for aligned (upper word 0) and split loads.

## Test plan
- Post-reset (word i holds i): lbu addr 0x14 -> o_wb_data 0x00000005, o_wb_load=1, one cycle later.
- sw 0xDEADBEEF @0x8 -> mask 1111, addr 2. Then lb @0xB -> 0xFFFFFFDE. lhu @0xA -> 0x0000DEAD.
- sb 0x000000AA @0x9 -> mask 0010, store_data 0x0000AA00. lw @0x8 then -> 0xDEADAABEF-free check: 0xDEADAAEF.
- With MEM_MISALIGN_SPLIT_EN: lw @0x6 after reset -> o_stall 1 cycle, words 1 then 2 accessed, result 0x00020000.
- Without macro: lw @0x6 -> ce=0, o_wb_valid=0, next cycle o_exc_misalign=1, o_exc_addr=0x6.
- Flush during SPLIT of sw 0x11223344 @0x6 -> word 1 = 0x33440001, word 2 unchanged (0x2), no writeback. m_rst low mid-SPLIT -> outputs 0.
